fft_mult_arb: RTL

//   Round-robin arbiter that shares one pipelined complex multiplier (fft_mult_comp) between
//   N_REQ butterfly lanes. It selects at most one requester per cycle and registers that

---
 rtl/fft_mult_arb.sv | 119 +++++++++++
 1 files changed

// File: rtl/fft_mult_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fft_mult_arb
//  Purpose  : Round-robin arbiter sharing one pipelined complex multiplier
//             between N_REQ butterfly lanes, with lane tags carried to output.
//  Revision : 1.0  initial release
// ============================================================================
module fft_mult_arb #(
    parameter int N_REQ    = 2,
    parameter int D_BIT    = 17,
    parameter int W_BIT    = 12,
    parameter int MULT_LAT = 1
) (
    input  logic                     iCLK,
    input  logic                     iRESET,
    input  logic                     iCLR,
    input  logic [N_REQ-1:0]         iREQ,
    input  logic [N_REQ*D_BIT-1:0]   iRE,
    input  logic [N_REQ*D_BIT-1:0]   iIM,
    input  logic [N_REQ*W_BIT-1:0]   iW_RE,
    input  logic [N_REQ*W_BIT-1:0]   iW_IM,
    output logic [N_REQ-1:0]         oGNT,
    output logic [D_BIT-1:0]         oM_RE,
    output logic [D_BIT-1:0]         oM_IM,
    output logic [W_BIT-1:0]         oM_W_RE,
    output logic [W_BIT-1:0]         oM_W_IM,
    input  logic [D_BIT-1:0]         iM_RE,
    input  logic [D_BIT-1:0]         iM_IM,
    output logic [N_REQ-1:0]         oVAL,
    output logic [D_BIT-1:0]         oRE,
    output logic [D_BIT-1:0]         oIM
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_next;
    logic [N_REQ-1:0] gnt;
    logic             gnt_any;
    logic [D_BIT-1:0] sel_re;
    logic [D_BIT-1:0] sel_im;
    logic [W_BIT-1:0] sel_w_re;
    logic [W_BIT-1:0] sel_w_im;
    logic [N_REQ-1:0] tag [MULT_LAT+1];

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    // Search starts at the pointer and wraps, so the lane after the last winner has priority.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && iREQ[wrap_add(ptr, i)]) begin
                gnt_idx = wrap_add(ptr, i);
                gnt_any = 1'b1;
            end
        end
        if (iCLR) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        sel_re   = iRE[int'(gnt_idx)*D_BIT +: D_BIT];
        sel_im   = iIM[int'(gnt_idx)*D_BIT +: D_BIT];
        sel_w_re = iW_RE[int'(gnt_idx)*W_BIT +: W_BIT];
        sel_w_im = iW_IM[int'(gnt_idx)*W_BIT +: W_BIT];
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            ptr     <= '0;
            oM_RE   <= '0;
            oM_IM   <= '0;
            oM_W_RE <= '0;
            oM_W_IM <= '0;
            for (int i = 0; i <= MULT_LAT; i++) begin
                tag[i] <= '0;
            end
        end else if (iCLR) begin
            ptr <= '0;
            for (int i = 0; i <= MULT_LAT; i++) begin
                tag[i] <= '0;
            end
        end else begin
            tag[0] <= gnt;
            for (int i = 1; i <= MULT_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            if (gnt_any) begin
                ptr     <= ptr_next;
                oM_RE   <= sel_re;
                oM_IM   <= sel_im;
                oM_W_RE <= sel_w_re;
                oM_W_IM <= sel_w_im;
            end
        end
    end

    // Grant must vanish the instant reset is raised, not at the next edge.
    assign oGNT = iRESET ? '0 : gnt;
    assign oVAL = tag[MULT_LAT];
    assign oRE  = iM_RE;
    assign oIM  = iM_IM;

endmodule
`default_nettype wire
